// File: rtl/seq_arith_pkg.sv
// seq_arith_pkg: shared state encoding and mode constants for the sequential arithmetic unit
package seq_arith_pkg;
  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DONE} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_MUL = 1'b1;
endpackage

// File: rtl/seq_arith_control.sv
// seq_arith_control: load/compute/done FSM with iteration counter and datapath enables
module seq_arith_control
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inputdata_ready,
  input  logic result_ack,
  input  logic mode,
  output logic loaddata,
  output logic busy,
  output logic result_valid,
  output logic load,
  output logic step,
  output logic capture,
  output logic mode_q
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  assign loaddata     = state == S_LOAD;
  assign busy         = state == S_COMPUTE;
  assign result_valid = state == S_DONE;
  assign load    = loaddata && inputdata_ready;
  assign step    = busy && mode_q == MODE_MUL;
  assign capture = busy && (mode_q == MODE_ADD || cnt == CNT_W'(WIDTH - 1));
  always_comb begin
    state_n = S_LOAD;
    state_n = state == S_LOAD    ? (inputdata_ready ? S_COMPUTE : S_LOAD) :
              state == S_COMPUTE ? (capture ? S_DONE : S_COMPUTE) :
              state == S_DONE    ? (result_ack ? S_LOAD : S_DONE) : S_LOAD;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_LOAD;
      cnt    <= '0;
      mode_q <= MODE_ADD;
    end else begin
      state  <= state_n;
      cnt    <= load ? '0 : step ? cnt + 1'b1 : cnt;
      mode_q <= load ? mode : mode_q;
    end
  end
endmodule

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: unsigned add (1 cycle) or shift-add multiply (WIDTH cycles) with valid/ack handshake
module seq_arith_unit
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inputdata_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             loaddata,
  output logic             busy,
  output logic [2*WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ack
);
  logic load, step, capture, mode_q;
  logic [2*WIDTH-1:0] a_reg, acc, acc_sum, sum;
  logic [WIDTH-1:0] b_reg;
  seq_arith_control #(.WIDTH(WIDTH)) u_ctrl (
    .clk(clk),
    .reset(reset),
    .inputdata_ready(inputdata_ready),
    .result_ack(result_ack),
    .mode(mode),
    .loaddata(loaddata),
    .busy(busy),
    .result_valid(result_valid),
    .load(load),
    .step(step),
    .capture(capture),
    .mode_q(mode_q)
  );
  assign acc_sum = acc + (b_reg[0] ? a_reg : '0);
  assign sum     = a_reg + {{WIDTH{1'b0}}, b_reg};
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      if (load) begin
        a_reg <= {{WIDTH{1'b0}}, operand_a};
        b_reg <= operand_b;
        acc   <= '0;
      end else if (step) begin
        a_reg <= a_reg << 1;
        b_reg <= b_reg >> 1;
        acc   <= acc_sum;
      end
      if (capture) result <= mode_q == MODE_MUL ? acc_sum : sum;
    end
  end
endmodule

// File: tb/tb_seq_arith_unit.sv
// tb_seq_arith_unit: directed vectors, scoreboard queue checked by an independent result monitor
module tb_seq_arith_unit;
  localparam int WIDTH = 8;
  typedef struct { logic [2*WIDTH-1:0] r; int c; } exp_t;
  logic clk = 0, reset = 1, inputdata_ready = 0, mode = 0, result_ack = 0;
  logic [WIDTH-1:0] operand_a = 0, operand_b = 0;
  logic loaddata, busy, result_valid;
  logic [2*WIDTH-1:0] result;
  exp_t q[$];
  int n_vec = 0, n_err = 0, cyc = 0;
  logic pv = 0;

  seq_arith_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .inputdata_ready(inputdata_ready), .mode(mode),
    .operand_a(operand_a), .operand_b(operand_b), .loaddata(loaddata), .busy(busy),
    .result(result), .result_valid(result_valid), .result_ack(result_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Result monitor: pops one expectation on each rising result_valid, checks value and edge index
  always @(negedge clk) begin
    if (!reset) begin
      if (result_valid && !pv) begin
        if (q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("result_value", result, e.r);
          check("result_latency", cyc, e.c);
        end
      end
      pv = result_valid;
    end else pv = 0;
  end

  task automatic wait_for_load();
    int i;
    @(negedge clk);
    for (i = 0; i < 40 && !loaddata; i++) @(negedge clk);
    if (!loaddata) check("load_timeout", 0, 1);
  endtask

  task automatic accept(input logic m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    wait_for_load();
    inputdata_ready = 1; mode = m; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    inputdata_ready = 0;
  endtask

  task automatic op(input logic m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                    input logic [2*WIDTH-1:0] r);
    accept(m, a, b);
    q.push_back('{r: r, c: cyc + (m ? WIDTH : 1)});
  endtask

  task automatic ack(input int hold, input logic [2*WIDTH-1:0] r);
    int i;
    @(negedge clk);
    for (i = 0; i < 40 && !result_valid; i++) @(negedge clk);
    if (!result_valid) check("valid_timeout", 0, 1);
    for (i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_result", result, r);
      check("hold_valid", result_valid, 1);
    end
    result_ack = 1;
    @(posedge clk); #1;
    result_ack = 0;
    @(negedge clk);
    check("ack_loaddata", loaddata, 1);
    check("ack_result_kept", result, r);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_loaddata", loaddata, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    // Multiply 13*11 with busy window and a long hold
    op(1, 13, 11, 143);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      check("mul_busy", busy, 1);
    end
    @(negedge clk);
    check("mul_busy_end", busy, 0);
    check("mul_valid", result_valid, 1);
    ack(5, 143);
    op(1, 255, 255, 65025); ack(0, 65025);
    op(1, 0, 200, 0);       ack(0, 0);
    op(0, 200, 100, 300);   ack(0, 300);
    op(0, 255, 255, 510);   ack(0, 510);
    // Input activity during compute must not disturb the running multiply
    op(1, 13, 11, 143);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      inputdata_ready = ~inputdata_ready; mode = ~mode;
      operand_a = 8'(i * 37 + 5); operand_b = 8'(i * 11 + 3);
    end
    inputdata_ready = 0;
    @(negedge clk);
    for (int i = 0; i < 40 && !result_valid; i++) @(negedge clk);
    check("toggle_valid", result_valid, 1);
    // Ack and new request together: one cycle in load before the new op is taken
    result_ack = 1; inputdata_ready = 1; mode = 0; operand_a = 2; operand_b = 3;
    @(posedge clk); #1;
    result_ack = 0;
    @(negedge clk);
    check("simul_loaddata", loaddata, 1);
    check("simul_valid", result_valid, 0);
    @(posedge clk); #1;
    q.push_back('{r: 5, c: cyc + 1});
    inputdata_ready = 0;
    @(negedge clk);
    check("simul_busy", busy, 1);
    ack(0, 5);
    // Reset mid-compute aborts the operation and clears the result
    accept(1, 100, 3);
    repeat (3) @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("mid_rst_loaddata", loaddata, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_result", result, 0);
    op(1, 6, 7, 42); ack(0, 42);
    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
    $fatal(1);
  end
endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
Parametrised sequential arithmetic unit; successor to the two-state load/multiply control unit. Adds a registered datapath, an iteration counter, and a selectable add/multiply mode. Uses a full valid/ready/ack handshake so the unit accepts repeated operations instead of locking in the compute state. Sits between the operand input registers/switches and the result display/consumer logic.

Parameters:
WIDTH, 8, operand width in bits (unsigned); legal range 2..32.
CNT_W, $clog2(WIDTH+1), iteration counter width (localparam, derived; not overridable).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
inputdata_ready  in  1  operands and mode valid; sampled only in S_LOAD
mode  in  1  0 = add, 1 = multiply; sampled with operands
operand_a  in  WIDTH  unsigned operand A
operand_b  in  WIDTH  unsigned operand B
loaddata  out  1  high in S_LOAD only (unit can accept operands)
busy  out  1  high in S_COMPUTE only
result  out  2*WIDTH  registered result; held stable while result_valid=1
result_valid  out  1  high in S_DONE only
result_ack  in  1  consumer has taken result; sampled only in S_DONE

Behaviour:
- Reset (synchronous, at clk edge with reset=1): state=S_LOAD, result=0, accumulator=0, counter=0. loaddata=1, busy=0, result_valid=0. Reset overrides every other input, including mid-COMPUTE and in S_DONE.
- States: S_LOAD, S_COMPUTE, S_DONE. Outputs are Moore-decoded from state only.
- S_LOAD:
  - On an edge with inputdata_ready=1: register operand_a into A_reg (2*WIDTH, zero-extended) and operand_b into B_reg. Register mode. Clear accumulator and counter. Go to S_COMPUTE.
  - Otherwise stay in S_LOAD.
- S_COMPUTE, multiply mode:
  - Each edge: if B_reg[0]=1, acc <= acc + A_reg. Then A_reg <<= 1, B_reg >>= 1, counter++.
  - When counter reaches WIDTH-1 on the current edge (the WIDTH-th iteration): result <= final acc and go to S_DONE.
  - Exactly WIDTH cycles in S_COMPUTE. No early termination when B_reg becomes 0; latency is fixed.
- S_COMPUTE, add mode:
  - One cycle. result <= zero-extend(A + B), a WIDTH+1-bit sum with no overflow loss. Go to S_DONE.
- Latency, with the accept edge at edge k:
  - Multiply: result_valid=1 after edge k+WIDTH.
  - Add: result_valid=1 after edge k+1.
- S_DONE:
  - result is held.
  - On an edge with result_ack=1: go to S_LOAD. result keeps its value; only result_valid drops.
  - Otherwise stay in S_DONE indefinitely.
- Ignored inputs:
  - inputdata_ready in S_COMPUTE or S_DONE is ignored. No queuing; operand or mode changes there have no effect.
  - result_ack outside S_DONE is ignored.
- Simultaneous result_ack=1 and inputdata_ready=1 in S_DONE: the ack is taken and the unit moves to S_LOAD. The new operands are not accepted on that edge; they are accepted on the next edge if still asserted.
- Arithmetic: all unsigned. Multiply result fits exactly in 2*WIDTH bits, so the accumulator never overflows.
- No X on outputs after the first reset edge. The unreachable state encoding returns to S_LOAD.

Decomposition:
- Package seq_arith_pkg:
  - state enum State {S_LOAD, S_COMPUTE, S_DONE}, logic [1:0]
  - mode constants MODE_ADD=1'b0, MODE_MUL=1'b1
- Sub-module seq_arith_control: FSM plus counter. Produces loaddata, busy, result_valid, and the shift/accumulate/capture enables.
- Top: instantiates seq_arith_control. Holds A_reg, B_reg, acc, and the result registers inline.

Test Plan:
1. reset=1 for 2 edges, then 0 -> loaddata=1, busy=0, result_valid=0, result=0.
2. WIDTH=8, mode=1, A=13, B=11, inputdata_ready pulse at edge k -> busy=1 for 8 cycles; result_valid=1 after edge k+8 with result=143. Hold result_ack=0 for 5 cycles -> result stays 143. Then ack -> loaddata=1.
3. mode=1, A=255, B=255 -> result=65025 after 8 cycles. Then A=0, B=200 -> result=0, still 8 cycles.
4. mode=0, A=200, B=100 -> result_valid after 1 cycle, result=300. Then A=255, B=255 -> result=510.
5. During S_COMPUTE, toggle inputdata_ready and change operands/mode -> result is unaffected (143 for the scenario-2 operands). In S_DONE, assert ack and inputdata_ready together -> S_LOAD for one cycle; the new op is accepted on the next edge.
6. Assert reset at the 4th S_COMPUTE cycle -> next edge gives loaddata=1, busy=0, result_valid=0, result=0. A fresh 6*7 then completes with 42.
